// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default clocking
// constants and the frame-length helper.
// The parity bit is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 2_000_000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Clock cycles in one frame: start + data + optional parity + stop bits.
  function automatic int frame_len(input int clks_per_bit, input int data_bits,
                                   input int parity_bits, input int stop_bits);
    return clks_per_bit * (1 + data_bits + parity_bits + stop_bits);
  endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Bit-period enable generator. It counts 0..CLKS_PER_BIT-1 and wraps.
// tick is high on the last cycle of every period. tick_next is high one
// cycle earlier, so a consumer can register an end-of-period output.
// clr restarts the period; it is intended to be shared with a future receiver.
module uart_bit_tick #(
  parameter int CLKS_PER_BIT = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // Period counter: held at zero by reset or clear, otherwise free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick      = (cnt == LAST);
  assign tick_next = (cnt == PRE);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a byte over valid/ready and serialises it
// LSB first as start, data, optional parity, and stop bits on an idle-high line.
// Bit timing comes from uart_bit_tick on the single system clock.
// Define UART_TX_PARITY_EN to insert a parity bit (odd when PARITY_ODD=1).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clki,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BCNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration time.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BCNT_W-1:0]    bit_cnt;
  logic                 bit_tick;
  logic                 bit_tick_next;
  logic                 accept;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_valid && (state == IDLE);

  // The period counter is held clear in IDLE, so the start bit gets a full period.
  uart_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_tick (
    .clk      (clki),
    .rst      (rst),
    .clr      (tx_ready),
    .tick     (bit_tick),
    .tick_next(bit_tick_next)
  );

  // Payload shift register: load on accept, shift out one bit per period.
  always_ff @(posedge clki) begin
    if (accept) begin
      shreg <= tx_data;
    end else if (bit_tick && (state == START || state == DATA)) begin
      shreg <= shreg >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  // Parity of the accepted payload, captured once at accept time.
  always_ff @(posedge clki) begin
    if (accept) begin
      par_bit <= (^tx_data) ^ 1'(PARITY_ODD);
    end
  end
`endif

  // Frame sequencer with registered line and end-of-frame outputs.
  always_ff @(posedge clki) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      tx_done <= 1'b0;
      bit_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (tx_valid) begin
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            txd     <= shreg[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= par_bit;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shreg[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state   <= STOP;
            txd     <= 1'b1;
            bit_cnt <= '0;
          end
        end
`endif
        STOP: begin
          txd <= 1'b1;
          // Raise done for exactly the final cycle of the last stop bit.
          if (bit_tick_next && bit_cnt == LAST_STOP) begin
            tx_done <= 1'b1;
          end
          if (bit_tick) begin
            if (bit_cnt == LAST_STOP) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          txd     <= 1'b1;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 25 clocks per bit, 8 data bits,
// 1 stop bit. With UART_TX_PARITY_EN defined, it also checks the parity bit
// (even on the main instance, odd on a second instance).
module tb_uart_tx_serializer;

  localparam int CPB = 25;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clki = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  int errors = 0;
  int checks = 0;

  always #10 clki = ~clki;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clki    (clki),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd     (txd),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

`ifdef UART_TX_PARITY_EN
  logic odd_ready;
  logic odd_txd;
  logic odd_busy;
  logic odd_done;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (1)
  ) dut_odd (
    .clki    (clki),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(odd_ready),
    .txd     (odd_txd),
    .tx_busy (odd_busy),
    .tx_done (odd_done)
  );
`endif

  task automatic step();
    @(posedge clki);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " txd"}, txd, 1'b1);
    chk({tag, " tx_ready"}, tx_ready, 1'b1);
    chk({tag, " tx_busy"}, tx_busy, 1'b0);
    chk({tag, " tx_done"}, tx_done, 1'b0);
  endtask

  // Called in the first cycle after the accept edge; returns in the first idle cycle.
  task automatic expect_frame(input logic [7:0] d, input bit wiggle);
    logic [NBITS-1:0] bits;
    logic [NBITS-1:0] bits_odd;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9]  = ^d;
    bits[10] = 1'b1;
`else
    bits[9]  = 1'b1;
`endif
    bits_odd = bits;
`ifdef UART_TX_PARITY_EN
    bits_odd[9] = ~(^d);
`endif
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("frame %h txd bit%0d cyc%0d", d, b, c), txd, bits[b]);
        chk($sformatf("frame %h busy bit%0d", d, b), tx_busy, 1'b1);
        chk($sformatf("frame %h ready bit%0d", d, b), tx_ready, 1'b0);
        chk($sformatf("frame %h done bit%0d cyc%0d", d, b, c), tx_done,
            (b == NBITS - 1) && (c == CPB - 1));
`ifdef UART_TX_PARITY_EN
        chk($sformatf("odd frame %h txd bit%0d", d, b), odd_txd, bits_odd[b]);
`else
        if (bits_odd != bits) chk("odd parity unused", 1'b0, 1'b1);
`endif
        if (wiggle) begin
          tx_data  = 8'($urandom);
          tx_valid = (c % 2 == 1);
        end
        step();
      end
    end
    check_idle($sformatf("after frame %h", d));
  endtask

  initial begin
    // Reset held: outputs at their reset values.
    repeat (3) step();
    check_idle("reset");
    rst = 1'b0;

    // Idle for 100 cycles with no valid.
    for (int i = 0; i < 100; i++) begin
      step();
      check_idle("idle100");
    end

    // Single frame 8'hA5.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    chk("ready before accept", tx_ready, 1'b1);
    step();
    tx_valid = 1'b0;
    expect_frame(8'hA5, 1'b0);

    // Back-to-back 8'h00 then 8'hFF with valid held high.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    step();
    tx_data = 8'hFF;
    expect_frame(8'h00, 1'b0);
    step();
    tx_valid = 1'b0;
    expect_frame(8'hFF, 1'b0);

    // Reset in the middle of an 8'h3C frame, then a clean new frame.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (59) step();
    chk("3C txd before reset", txd, 1'b0);
    chk("3C busy before reset", tx_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("after mid-frame reset");
    for (int i = 0; i < 9; i++) begin
      step();
      check_idle("post-reset idle");
    end
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    expect_frame(8'h3C, 1'b0);

    // Inputs disturbed during the frame must not alter it or cause an accept.
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    step();
    expect_frame(8'h96, 1'b1);
    tx_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      check_idle("no extra accept");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
